// File: rtl/core_memory_arbiter_pkg.sv
// Shared encodings and constants for the core memory arbiter: FSM states,
// grant owner, timeout read value and the latched bus request record.
package core_memory_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } arbState_t;

    typedef enum logic {
        FETCH = 1'b0,
        DATA  = 1'b1
    } grant_t;

    localparam logic [31:0] TIMEOUT_READ_DATA = 32'hFFFF_FFFF;

    typedef struct packed {
        logic        writeEnable;
        logic [3:0]  byteSelect;
        logic [31:0] address;
        logic [31:0] writeData;
    } busRequest_t;

    function automatic logic [31:0] wordAlign(input logic [31:0] address);
        return {address[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/core_memory_arbiter_counter.sv
// Wait-cycle counter for one bus transaction: synchronous clear, count enable,
// and a terminal flag raised on the last permitted wait cycle.
module memory_timeout_counter #(
    parameter int LIMIT = 255,
    parameter int WIDTH = $clog2(LIMIT)
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic terminal
);

    localparam logic [WIDTH-1:0] LAST_COUNT = WIDTH'(LIMIT - 1);

    logic [WIDTH-1:0] count;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of its neighbours.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + WIDTH'(1);
        end
    end

    assign terminal = (count == LAST_COUNT);

endmodule

// File: rtl/core_memory_arbiter.sv
// Round-robin arbiter sharing the core memory bus between instruction fetch
// and load/store, with registered bus request, ack handshake and timeout.
module core_memory_arbiter
    import core_memory_arbiter_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        fetchEnable,
    input  logic [31:0] fetchAddress,
    output logic [31:0] fetchReadData,
    output logic        fetchBusy,

    input  logic        dataEnable,
    input  logic        dataWriteEnable,
    input  logic [3:0]  dataByteSelect,
    input  logic [31:0] dataAddress,
    input  logic [31:0] dataWriteData,
    output logic [31:0] dataReadData,
    output logic        dataBusy,

    output logic        memEnable,
    output logic        memWriteEnable,
    output logic [3:0]  memByteSelect,
    output logic [31:0] memAddress,
    output logic [31:0] memWriteData,
    input  logic [31:0] memReadData,
    input  logic        memAck,
    output logic        memTimeout
);

    arbState_t   state, nextState;
    grant_t      grant, lastGrant, pickGrant;
    busRequest_t pickRequest;
    logic        pickValid;
    logic        startAccess;
    logic        accessAck;
    logic        accessExpire;
    logic        counterEnable;
    logic        counterTerminal;

    memory_timeout_counter #(
        .LIMIT (TIMEOUT_CYCLES)
    ) timeoutCounter (
        .clk      (clk),
        .rst      (rst),
        .clear    (startAccess),
        .enable   (counterEnable),
        .terminal (counterTerminal)
    );

    // On a conflict the requester that did not own the previous transaction wins.
    always_comb begin
        pickValid = fetchEnable || dataEnable;
        pickGrant = FETCH;
        if (fetchEnable && dataEnable) begin
            pickGrant = (lastGrant == FETCH) ? DATA : FETCH;
        end else if (dataEnable) begin
            pickGrant = DATA;
        end

        if (pickGrant == DATA) begin
            pickRequest = '{writeEnable: dataWriteEnable,
                            byteSelect:  dataByteSelect,
                            address:     wordAlign(dataAddress),
                            writeData:   dataWriteData};
        end else begin
            pickRequest = '{writeEnable: 1'b0,
                            byteSelect:  4'hF,
                            address:     wordAlign(fetchAddress),
                            writeData:   32'h0};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // NOTE: every output of this block gets a default first, so no path
    // through the case can leave a value held and infer a latch.
    always_comb begin
        nextState     = state;
        startAccess   = 1'b0;
        accessAck     = 1'b0;
        accessExpire  = 1'b0;
        counterEnable = 1'b0;
        unique case (state)
            IDLE: begin
                if (pickValid) begin
                    startAccess = 1'b1;
                    nextState   = ACCESS;
                end
            end
            ACCESS: begin
                accessAck     = memAck;
                accessExpire  = !memAck && counterTerminal;
                counterEnable = !memAck;
                if (accessAck || accessExpire) begin
                    nextState = DONE;
                end
            end
            DONE: begin
                nextState = IDLE;
            end
            default: begin
                nextState = IDLE;
            end
        endcase
    end

    // NOTE: the read-data registers are plain flops, so they are reset along
    // with the bus request; nothing in this block is a RAM array.
    always_ff @(posedge clk) begin
        if (rst) begin
            grant          <= FETCH;
            lastGrant      <= FETCH;
            memEnable      <= 1'b0;
            memWriteEnable <= 1'b0;
            memByteSelect  <= '0;
            memAddress     <= '0;
            memWriteData   <= '0;
            memTimeout     <= 1'b0;
            fetchReadData  <= '0;
            dataReadData   <= '0;
        end else begin
            memTimeout <= accessExpire;

            if (startAccess) begin
                grant          <= pickGrant;
                memEnable      <= 1'b1;
                memWriteEnable <= pickRequest.writeEnable;
                memByteSelect  <= pickRequest.byteSelect;
                memAddress     <= pickRequest.address;
                memWriteData   <= pickRequest.writeData;
            end

            // Completion is unconditional: a withdrawn request still lands here.
            if (accessAck || accessExpire) begin
                memEnable      <= 1'b0;
                memWriteEnable <= 1'b0;
                memByteSelect  <= '0;
                memAddress     <= '0;
                memWriteData   <= '0;
                if (grant == DATA) begin
                    dataReadData <= accessAck ? memReadData : TIMEOUT_READ_DATA;
                end else begin
                    fetchReadData <= accessAck ? memReadData : TIMEOUT_READ_DATA;
                end
            end

            if (state == DONE) begin
                lastGrant <= grant;
            end
        end
    end

    assign fetchBusy = fetchEnable && !(state == DONE && grant == FETCH);
    assign dataBusy  = dataEnable  && !(state == DONE && grant == DATA);

endmodule

// File: doc/core_memory_arbiter.md
# core_memory_arbiter

Shares a single core-side memory bus between the instruction fetch port and the operation stage's load/store port. Each accepted request is sequenced through a registered bus transaction with an ack handshake and a timeout. Completion is returned to the requester as a one-cycle busy release with registered read data. It sits between the pipe stages (fetch, PipeOperation memory outputs) and the core's local memory/peripheral interface.

## Interface
- `TIMEOUT_CYCLES`, 255: max cycles `memEnable` stays high awaiting `memAck`. Legal range 2..65535.
- `clk` input 1: core clock.
- `rst` input 1: synchronous, active-high reset.
- `fetchEnable` input 1: fetch request, held until the completion cycle.
- `fetchAddress` input 32: word address; bits [1:0] ignored.
- `fetchReadData` output 32: registered instruction word, valid in the fetch completion cycle.
- `fetchBusy` output 1: fetch request not yet complete.
- `dataEnable`, `dataWriteEnable` input 1 each: load/store request and write qualifier.
- `dataByteSelect` input 4, `dataAddress` input 32, `dataWriteData` input 32: from the operation stage.
- `dataReadData` output 32: registered load word, valid in the data completion cycle.
- `dataBusy` output 1: data request not yet complete.
- `memEnable`, `memWriteEnable` output 1 each; `memByteSelect` output 4; `memAddress` output 32; `memWriteData` output 32: registered bus request.
- `memReadData` input 32, `memAck` input 1: bus response.
- `memTimeout` output 1: one-cycle pulse when a transaction is abandoned.

## Operation
- **States:** IDLE, ACCESS, DONE. Register `grant` selects FETCH or DATA. Register `lastGrant` resets to FETCH.
- **IDLE:**
  - If exactly one enable is high, grant it.
  - If both are high, grant the opposite of `lastGrant` (round-robin). After reset, data wins the first conflict.
  - Latch address, byte select, write enable and write data, then go to ACCESS.
  - Fetch transactions drive `memByteSelect=4'hF` and `memWriteEnable=0`.
  - `memAddress` = {addr[31:2], 2'b00}.
- **ACCESS:**
  - `memEnable` is high and all bus outputs are stable.
  - Timeout counter starts at 0 and increments each cycle with `memAck` low.
  - `memAck` high: capture `memReadData` into the granted requester's read-data register, then go to DONE.
  - No ack while counter == `TIMEOUT_CYCLES`-1: load 32'hFFFF_FFFF into the read-data register, pulse `memTimeout` in the following DONE cycle, then go to DONE.
  - Ack in the same cycle as the timeout limit counts as a normal ack.
- **DONE:** one cycle. Update `lastGrant` to `grant`, then go to IDLE. Back-to-back requests therefore cost one idle cycle.
- **Busy outputs:** `xBusy = xEnable && !(state==DONE && grant==x)`. Combinational from registered state.
- **Requester drops enable mid-ACCESS:**
  - The bus transaction still completes; it cannot be aborted.
  - Read data is still captured, and `lastGrant` still updates.
- **Write completion:** a write request completes on ack. Its read-data register is loaded with `memReadData` and has no defined meaning.
- The non-granted requester's read-data register holds its previous value.

## Timing
- **Reset values:**
  - state=IDLE, `lastGrant`=FETCH, counter=0.
  - All `mem*` outputs 0, `memTimeout`=0, both read-data registers 0.
  - `xBusy` equals `xEnable`.
- **Latency:** request seen in IDLE at cycle 0 → `memEnable` at cycle 1 → ack at cycle k≥1 → DONE with busy low at cycle k+1.
  - Minimum request-to-completion latency is 2 cycles.
- **Reset mid-ACCESS:** `memEnable` is low after the reset edge and the in-flight result is discarded. The bus slave must tolerate the dropped request.
- `memAck` is ignored outside ACCESS.
- Counter width is $clog2(`TIMEOUT_CYCLES`). Counter clears on entry to ACCESS.

## Structure
- The shared core package holds:
  - the state encoding (IDLE/ACCESS/DONE)
  - the grant encoding (FETCH/DATA)
  - the 32'hFFFF_FFFF timeout read value constant.
- One sub-module, `memory_timeout_counter`, contains the counter with clear, enable, and a terminal-count output.
- Arbitration and the FSM stay in the top module.

## Test plan
- **Single fetch:** `fetchEnable`, address 0x100, ack on 1st ACCESS cycle with 0x00000013.
  - `memAddress`=0x100 and `memByteSelect`=F at cycle 1.
  - `fetchBusy` low at cycle 2 with `fetchReadData`=0x00000013.
- **Simultaneous requests after reset:**
  - Data wins first.
  - With both held, the next grant is fetch.
  - With both held again, the next grant is data (alternation).
- **Store:** address 0x2003, byte select 4'b1000, write data 0xAB000000, ack after 3 wait cycles.
  - Bus shows 0x2000, select 1000, write enable 1 for 4 cycles.
  - `dataBusy` low only in DONE.
- **Timeout:** `TIMEOUT_CYCLES`=4, no ack.
  - `memEnable` high exactly 4 cycles.
  - `memTimeout` pulses once.
  - `dataReadData`=0xFFFFFFFF.
  - Ack arriving on the 4th cycle instead completes normally with no pulse.
- **Withdrawal and reset:**
  - Drop `fetchEnable` mid-ACCESS: the transaction still completes and `fetchBusy` stays 0.
  - `rst` mid-ACCESS: `memEnable`=0 next cycle and the state returns to IDLE.
